axi_demux_id_tracker: RTL and testbench

//  Per-ID outstanding-transaction tracker for the AXI demux, with programmable limits per ID and in total.

---
 rtl/axi_demux_id_tracker.sv | 158 +++++++++++++++
 tb/tb_axi_demux_id_tracker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_demux_id_tracker.sv
// rtl/axi_demux_id_tracker.sv - per-ID outstanding transaction tracker for the AXI demux
// Counts in-flight transactions per ID, per master port and in total; blocks reordering or over-limit pushes.
module axi_demux_id_tracker #(
  parameter int unsigned AxiIdBits    = 4,
  parameter int unsigned CounterWidth = 4,
  parameter int unsigned MaxTxnsPerId = 8,
  parameter int unsigned MaxTxnsTotal = 16,
  parameter int unsigned NoMstPorts   = 4,
  localparam int unsigned NoCnt    = 2**AxiIdBits,
  localparam int unsigned TotWidth = $clog2(MaxTxnsTotal + 1),
  localparam int unsigned SelWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AxiIdBits-1:0]  lookup_id_i,
  output logic [SelWidth-1:0]   lookup_sel_o,
  output logic                  lookup_occ_o,
  input  logic [AxiIdBits-1:0]  push_id_i,
  input  logic [SelWidth-1:0]   push_sel_i,
  input  logic                  push_i,
  output logic                  push_ready_o,
  input  logic [AxiIdBits-1:0]  inject_id_i,
  input  logic                  inject_i,
  input  logic [AxiIdBits-1:0]  pop_id_i,
  input  logic                  pop_i,
  output logic [TotWidth-1:0]   total_cnt_o,
  output logic [NoMstPorts-1:0] mst_busy_o,
  output logic [1:0]            err_o,
  input  logic                  err_clr_i
);
  localparam int unsigned CntMax = (1 << CounterWidth) - 1;

  logic [CounterWidth-1:0] cnt_q      [NoCnt];
  logic [CounterWidth-1:0] cnt_d      [NoCnt];
  logic [SelWidth-1:0]     sel_q      [NoCnt];
  logic [SelWidth-1:0]     sel_d      [NoCnt];
  logic [TotWidth-1:0]     port_cnt_q [NoMstPorts];
  logic [TotWidth-1:0]     port_cnt_d [NoMstPorts];
  logic [TotWidth-1:0]     total_q, total_d;
  logic [1:0]              err_q, err_d;

  logic [1:0]          need;
  logic                inject_other;
  logic                push_acc, inj_acc, pop_acc;
  logic [SelWidth-1:0] inj_port, pop_port;
  logic [1:0]          err_set;

  // Admission and acceptance decisions use registered counts only; pops give no credit.
  always_comb begin
    need         = (inject_i && (inject_id_i == push_id_i)) ? 2'd2 : 2'd1;
    inject_other = inject_i && (inject_id_i != push_id_i);
    push_ready_o = 1'b1;
    if ((cnt_q[push_id_i] != '0) && (sel_q[push_id_i] != push_sel_i)) begin
      push_ready_o = 1'b0;
    end
    if (32'(cnt_q[push_id_i]) + 32'(need) > MaxTxnsPerId) begin
      push_ready_o = 1'b0;
    end
    if (32'(total_q) + 32'(need) + 32'(inject_other) > MaxTxnsTotal) begin
      push_ready_o = 1'b0;
    end
    push_acc = push_i && push_ready_o;
    inj_acc  = inject_i && (32'(cnt_q[inject_id_i]) < CntMax) && (32'(total_q) < MaxTxnsTotal);
    pop_acc  = pop_i && (cnt_q[pop_id_i] != '0);
    inj_port = (push_acc && (push_id_i == inject_id_i)) ? push_sel_i : sel_q[inject_id_i];
    pop_port = sel_q[pop_id_i];
    err_set  = {inject_i && !inj_acc, pop_i && !pop_acc};
  end

  // All events on one ID fold into a single net delta; intermediate wrap cancels out.
  always_comb begin
    for (int i = 0; i < NoCnt; i++) begin
      cnt_d[i] = cnt_q[i];
      sel_d[i] = sel_q[i];
      if (push_acc && (push_id_i == AxiIdBits'(i))) begin
        cnt_d[i] = cnt_d[i] + CounterWidth'(1);
        sel_d[i] = push_sel_i;
      end
      if (inj_acc && (inject_id_i == AxiIdBits'(i))) begin
        cnt_d[i] = cnt_d[i] + CounterWidth'(1);
      end
      if (pop_acc && (pop_id_i == AxiIdBits'(i))) begin
        cnt_d[i] = cnt_d[i] - CounterWidth'(1);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NoMstPorts; p++) begin
      port_cnt_d[p] = port_cnt_q[p];
      if (push_acc && (push_sel_i == SelWidth'(p))) begin
        port_cnt_d[p] = port_cnt_d[p] + TotWidth'(1);
      end
      if (inj_acc && (inj_port == SelWidth'(p))) begin
        port_cnt_d[p] = port_cnt_d[p] + TotWidth'(1);
      end
      if (pop_acc && (pop_port == SelWidth'(p))) begin
        port_cnt_d[p] = port_cnt_d[p] - TotWidth'(1);
      end
    end
  end

  always_comb begin
    total_d = total_q + TotWidth'(push_acc) + TotWidth'(inj_acc) - TotWidth'(pop_acc);
    err_d   = err_clr_i ? err_set : (err_q | err_set);
  end

  always_comb begin
    lookup_occ_o = (cnt_q[lookup_id_i] != '0);
    lookup_sel_o = sel_q[lookup_id_i];
    total_cnt_o  = total_q;
    err_o        = err_q;
    for (int p = 0; p < NoMstPorts; p++) begin
      mst_busy_o[p] = (port_cnt_q[p] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NoCnt; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
      for (int p = 0; p < NoMstPorts; p++) begin
        port_cnt_q[p] <= '0;
      end
      total_q <= '0;
      err_q   <= '0;
    end else begin
      for (int i = 0; i < NoCnt; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
      end
      for (int p = 0; p < NoMstPorts; p++) begin
        port_cnt_q[p] <= port_cnt_d[p];
      end
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

`ifndef SYNTHESIS
  logic [31:0] port_sum;
  always_comb begin
    port_sum = '0;
    for (int p = 0; p < NoMstPorts; p++) begin
      port_sum = port_sum + 32'(port_cnt_q[p]);
    end
  end

  a_push_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_acc |-> !((cnt_q[push_id_i] != '0) && (sel_q[push_id_i] != push_sel_i)));
  a_total_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(total_q) <= MaxTxnsTotal);
  a_port_sum: assert property (@(posedge clk_i) disable iff (!rst_ni)
    port_sum == 32'(total_q));
`endif
endmodule

// File: tb/tb_axi_demux_id_tracker.sv
// tb/tb_axi_demux_id_tracker.sv - scoreboard bench for axi_demux_id_tracker
// Driver pushes model expectations each cycle; an independent monitor pops and compares.
module tb_axi_demux_id_tracker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] lookup_id = '0, push_id = '0, inject_id = '0, pop_id = '0;
  logic [1:0] push_sel = '0;
  logic       push = 1'b0, inject = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [1:0] lookup_sel;
  logic       lookup_occ, push_ready;
  logic [4:0] total_cnt;
  logic [3:0] mst_busy;
  logic [1:0] err;

  always #5 clk = ~clk;

  axi_demux_id_tracker dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lookup_id_i(lookup_id), .lookup_sel_o(lookup_sel), .lookup_occ_o(lookup_occ),
    .push_id_i(push_id), .push_sel_i(push_sel), .push_i(push), .push_ready_o(push_ready),
    .inject_id_i(inject_id), .inject_i(inject),
    .pop_id_i(pop_id), .pop_i(pop),
    .total_cnt_o(total_cnt), .mst_busy_o(mst_busy), .err_o(err), .err_clr_i(err_clr)
  );

  typedef struct {
    logic       ready;
    logic       occ;
    logic [1:0] lsel;
    logic [4:0] total;
    logic [3:0] busy;
    logic [1:0] err;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         m_cnt[16];
  int         m_sel[16];
  logic [1:0] m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Explicit spot checks, sampled after the monitor slot of the same cycle.
  task automatic xchk(input string name, input int act_sel, input int exp);
    int act;
    #3;
    case (act_sel)
      0: act = int'(push_ready);
      1: act = int'(lookup_occ);
      2: act = int'(total_cnt);
      3: act = int'(mst_busy);
      default: act = int'(err);
    endcase
    chk(name, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("push_ready", int'(push_ready), int'(e.ready));
        chk("lookup_occ", int'(lookup_occ), int'(e.occ));
        chk("lookup_sel", int'(lookup_sel), int'(e.lsel));
        chk("total_cnt",  int'(total_cnt),  int'(e.total));
        chk("mst_busy",   int'(mst_busy),   int'(e.busy));
        chk("err",        int'(err),        int'(e.err));
      end
    end
  end

  // One clock of stimulus; the model sees the same registered view the DUT does.
  task automatic cyc(input bit rst, input bit p, input int pid, input int psel,
                     input bit inj, input int iid, input bit pp, input int popid,
                     input bit clr, input int lid);
    exp_t       e;
    int         tot, need;
    bit         other, rdy, inj_ok, pop_ok;
    logic [1:0] set;
    @(negedge clk);
    rst_n = !rst;
    push = p; push_id = 4'(pid); push_sel = 2'(psel);
    inject = inj; inject_id = 4'(iid);
    pop = pp; pop_id = 4'(popid);
    err_clr = clr; lookup_id = 4'(lid);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_cnt[i] = 0;
        m_sel[i] = 0;
      end
      m_err = 2'b00;
    end
    tot = 0;
    for (int i = 0; i < 16; i++) tot += m_cnt[i];
    need  = (inj && iid == pid) ? 2 : 1;
    other = inj && (iid != pid);
    rdy   = !(m_cnt[pid] > 0 && m_sel[pid] != psel) && (m_cnt[pid] + need <= 8)
            && (tot + need + int'(other) <= 16);
    e.ready = rdy;
    e.occ   = (m_cnt[lid] > 0);
    e.lsel  = 2'(m_sel[lid]);
    e.total = 5'(tot);
    e.busy  = '0;
    for (int i = 0; i < 16; i++) if (m_cnt[i] > 0) e.busy[m_sel[i]] = 1'b1;
    e.err   = m_err;
    sb.push_back(e);
    if (!rst) begin
      inj_ok = inj && (m_cnt[iid] < 15) && (tot < 16);
      pop_ok = pp && (m_cnt[popid] > 0);
      set    = {inj && !inj_ok, pp && !pop_ok};
      m_err  = clr ? set : (m_err | set);
      if (pop_ok) m_cnt[popid]--;
      if (p && rdy) begin
        m_cnt[pid]++;
        m_sel[pid] = psel;
      end
      if (inj_ok) m_cnt[iid]++;
    end
  endtask

  task automatic idle(input int lid);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, lid);
  endtask

  initial begin : driver
    bit p, inj, pp, clr;
    int pid, psel;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4, 1, 0, 0, 0, 0, 0, 4);
    xchk("reset_ready", 0, 1);
    xchk("reset_total", 2, 0);
    idle(3);
    xchk("reset_busy", 3, 0);

    repeat (3) cyc(0, 1, 3, 2, 0, 0, 0, 0, 0, 3);
    idle(3);
    xchk("id3_busy_sel2", 3, 4'b0100);
    xchk("id3_total3", 2, 3);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, 3);
    idle(3);
    xchk("id3_drained_occ", 1, 0);
    xchk("id3_drained_busy", 3, 0);

    cyc(0, 1, 3, 2, 0, 0, 0, 0, 0, 3);
    cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 3);
    xchk("reorder_blocked", 0, 0);
    cyc(0, 1, 3, 1, 0, 0, 1, 3, 0, 3);
    xchk("reorder_pop_no_credit", 0, 0);
    cyc(0, 1, 3, 1, 0, 0, 0, 0, 0, 3);
    xchk("reorder_after_pop", 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, 3);

    repeat (8) cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 5);
    cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 5);
    xchk("per_id_limit", 0, 0);
    xchk("per_id_total8", 2, 8);
    cyc(0, 1, 5, 0, 0, 0, 1, 5, 0, 5);
    xchk("limit_push_pop_blocked", 0, 0);
    cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 5);
    xchk("limit_after_pop", 2, 7);
    idle(5);

    repeat (6) cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 1, 1, 0, 0, 0, 1);
    xchk("push_inject_ready", 0, 1);
    idle(1);
    xchk("push_inject_total16", 2, 16);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    cyc(0, 1, 2, 0, 0, 0, 0, 0, 0, 2);
    cyc(0, 1, 1, 0, 1, 1, 0, 0, 0, 1);
    xchk("full_push_inject_blocked", 0, 0);
    idle(1);
    xchk("inject_overflow_err", 4, 2'b10);
    xchk("inject_dropped_total", 2, 16);

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0);
    xchk("pop_empty_err", 4, 2'b01);
    idle(0);
    xchk("pop_empty_sticky", 4, 2'b01);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    xchk("err_cleared", 4, 0);

    cyc(1, 1, 5, 0, 1, 2, 1, 1, 0, 5);
    idle(5);
    xchk("mid_reset_total", 2, 0);
    xchk("mid_reset_occ", 1, 0);

    for (int n = 0; n < 10000; n++) begin
      pid  = $urandom_range(15);
      psel = ($urandom_range(9) < 8) ? (pid % 4) : $urandom_range(3);
      p    = ($urandom_range(9) < 6);
      inj  = ($urandom_range(7) == 0);
      pp   = ($urandom_range(9) < 4);
      clr  = ($urandom_range(15) == 0);
      cyc((n == 5000), p, pid, psel, inj, $urandom_range(15), pp, $urandom_range(15),
          clr, $urandom_range(15));
    end
    idle(0);

    repeat (4) @(negedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
